instr_encoder: RTL and testbench

- Inverse of the control decoder: packs opcode/register/immediate fields into 16-bit instruction words and streams them into instruction memory.
- Used by the boot/program loader and by the test harness to build programs in imem.
- Validates field ranges per format, so only well-formed words are written.
- Provides a valid/ready input handshake, a registered write stage and a fill-pointer state machine.

---
 rtl/instr_pkg.sv | 55 +++++
 rtl/instr_pack.sv | 56 +++++
 rtl/instr_encoder.sv | 146 ++++++++++++++
 tb/tb_instr_encoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// instr_pkg: shared instruction-set definitions for the encoder and decoder.
//   op_e        - opcode enumeration (OP_LW=0 .. OP_BNEZ=11, 12..15 unused)
//   fmt_e       - encoding format {FMT_R, FMT_N, FMT_MK, FMT_B}
//   op_fmt()    - opcode -> format lookup (legal opcodes only)
//   ERR_*       - err_code values reported by the encoder
//   *_LSB       - field bit positions inside the 16-bit word
package instr_pkg;

    typedef enum logic [3:0] {
        OP_LW   = 4'd0,
        OP_SW   = 4'd1,
        OP_ADD  = 4'd2,
        OP_ADDI = 4'd3,
        OP_SUB  = 4'd4,
        OP_LI   = 4'd5,
        OP_AND  = 4'd6,
        OP_OR   = 4'd7,
        OP_SLLI = 4'd8,
        OP_SRLI = 4'd9,
        OP_BEQZ = 4'd10,
        OP_BNEZ = 4'd11
    } op_e;

    typedef enum logic [1:0] {
        FMT_R  = 2'd0,
        FMT_N  = 2'd1,
        FMT_MK = 2'd2,
        FMT_B  = 2'd3
    } fmt_e;

    localparam logic [3:0] OP_LAST  = 4'd11;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OPC  = 2'b01;
    localparam logic [1:0] ERR_IMM  = 2'b10;
    localparam logic [1:0] ERR_RS1  = 2'b11;

    localparam int OPC_LSB  = 12;
    localparam int RD_LSB   = 9;
    localparam int RS1_LSB  = 6;
    localparam int RS2_LSB  = 3;
    localparam int IMM7_LSB = 2;

    // Only meaningful for opcodes 0..11; out-of-range opcodes fall into
    // FMT_MK here and must be rejected by the caller first.
    function automatic fmt_e op_fmt(input logic [3:0] op);
        case (op)
            4'd2, 4'd4, 4'd6, 4'd7: op_fmt = FMT_R;
            4'd3, 4'd8, 4'd9:       op_fmt = FMT_N;
            4'd10, 4'd11:           op_fmt = FMT_B;
            default:                op_fmt = FMT_MK;
        endcase
    endfunction

endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational field packer. Builds the 16-bit instruction word
// from the field bundle and reports whether the bundle is well formed.
//   opcode_i, rd_i, rs1_i, rs2_i, imm_i - field bundle (imm_i signed 9-bit)
//   word_o     - encoded word (only meaningful when legal_o)
//   legal_o    - bundle passes all range checks
//   err_code_o - ERR_NONE when legal, otherwise the first failing check:
//                opcode, then immediate range, then rs1[2] in M/K format
module instr_pack
    import instr_pkg::*;
(
    input  logic [3:0]  opcode_i,
    input  logic [2:0]  rd_i,
    input  logic [2:0]  rs1_i,
    input  logic [2:0]  rs2_i,
    input  logic [8:0]  imm_i,
    output logic [15:0] word_o,
    output logic        legal_o,
    output logic [1:0]  err_code_o
);

    logic       opc_ok;
    logic       imm7_ok;
    logic       nzimm_ok;
    logic [8:0] low;

    // A 9-bit signed value fits in N bits when its top (9-N+1) bits agree.
    assign opc_ok   = (opcode_i <= OP_LAST);
    assign imm7_ok  = (&imm_i[8:6]) | ~(|imm_i[8:6]);
    assign nzimm_ok = ((&imm_i[8:5]) | ~(|imm_i[8:5])) & (|imm_i);

    always_comb begin
        low        = '0;
        err_code_o = ERR_NONE;
        if (!opc_ok) begin
            err_code_o = ERR_OPC;
        end else begin
            case (op_fmt(opcode_i))
                FMT_R:  low = {rs1_i, rs2_i, 3'b000};
                FMT_N: begin
                    if (!nzimm_ok) err_code_o = ERR_IMM;
                    low = {rs1_i, imm_i[5:0]};
                end
                FMT_MK: begin
                    if (!imm7_ok)      err_code_o = ERR_IMM;
                    else if (rs1_i[2]) err_code_o = ERR_RS1;
                    low = {imm_i[6:0], rs1_i[1:0]};
                end
                FMT_B:  low = imm_i;
            endcase
        end
    end

    assign word_o  = {opcode_i, rd_i, low};
    assign legal_o = (err_code_o == ERR_NONE);

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts field bundles over a valid/ready handshake, packs
// them via instr_pack and streams legal words into instruction memory from
// BASE upward. Illegal bundles produce a one-cycle err_o pulse instead.
//   clk, rst_n           - clock, synchronous active-low reset
//   start_i              - arm / restart the fill at BASE
//   in_valid_i/ready_o   - bundle handshake (ready only while filling)
//   opcode_i..imm_i      - field bundle
//   imem_we_o/addr/wdata - registered write port, one cycle after accept
//   count_o              - words written since start
//   err_o, err_code_o    - reject pulse and sticky reason code
//   full_o               - DEPTH words written, input blocked until start_i
// Optional: INSTR_ENCODER_CHECKSUM_EN adds checksum_o, the XOR of every word
// written since the last start.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DEPTH = 256,
    parameter int BASE  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [3:0]    opcode_i,
    input  logic [2:0]    rd_i,
    input  logic [2:0]    rs1_i,
    input  logic [2:0]    rs2_i,
    input  logic [8:0]    imm_i,
    output logic          imem_we_o,
    output logic [AW-1:0] imem_addr_o,
    output logic [15:0]   imem_wdata_o,
    output logic [AW:0]   count_o,
    output logic          err_o,
    output logic [1:0]    err_code_o,
    output logic          full_o
`ifdef INSTR_ENCODER_CHECKSUM_EN
   ,output logic [15:0]   checksum_o
`endif
);

    localparam logic [1:0]    S_IDLE = 2'd0;
    localparam logic [1:0]    S_RUN  = 2'd1;
    localparam logic [1:0]    S_FULL = 2'd2;

    localparam logic [AW-1:0] BASE_A = AW'(BASE);
    localparam logic [AW:0]   LAST_C = (AW+1)'(DEPTH - 1);

    logic [1:0]    state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;
    logic [15:0]   csum_q, csum_d;

    logic [15:0]   word;
    logic          legal;
    logic [1:0]    code;
    logic          accept;

    instr_pack u_pack (
        .opcode_i   (opcode_i),
        .rd_i       (rd_i),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .imm_i      (imm_i),
        .word_o     (word),
        .legal_o    (legal),
        .err_code_o (code)
    );

    // start_i takes priority: a bundle offered in the same cycle stays
    // pending and is taken after the restart.
    assign accept = in_valid_i & in_ready_o & ~start_i;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        code_d  = code_q;
        csum_d  = csum_q;
        if (start_i) begin
            state_d = S_RUN;
            count_d = '0;
            csum_d  = '0;
        end else if (accept) begin
            if (legal) begin
                we_d    = 1'b1;
                addr_d  = BASE_A + count_q[AW-1:0];
                wdata_d = word;
                count_d = count_q + 1'b1;
                csum_d  = csum_q ^ word;
                if (count_q == LAST_C) state_d = S_FULL;
            end else begin
                err_d  = 1'b1;
                code_d = code;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            code_q  <= code_d;
            csum_q  <= csum_d;
        end
    end

    assign in_ready_o   = (state_q == S_RUN);
    assign full_o       = (state_q == S_FULL);
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign count_o      = count_q;
    assign err_o        = err_q;
    assign err_code_o   = code_q;

`ifdef INSTR_ENCODER_CHECKSUM_EN
    assign checksum_o = csum_q;
`else
    // Accumulator is left unobserved in the default build and trims away.
    logic unused_csum;
    assign unused_csum = ^csum_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam int BASE  = 0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [3:0]    opcode_i;
    logic [2:0]    rd_i, rs1_i, rs2_i;
    logic [8:0]    imm_i;
    logic          imem_we_o;
    logic [AW-1:0] imem_addr_o;
    logic [15:0]   imem_wdata_o;
    logic [AW:0]   count_o;
    logic          err_o;
    logic [1:0]    err_code_o;
    logic          full_o;
`ifdef INSTR_ENCODER_CHECKSUM_EN
    logic [15:0]   checksum_o;
`endif

    instr_encoder #(.AW(AW), .DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .opcode_i     (opcode_i),
        .rd_i         (rd_i),
        .rs1_i        (rs1_i),
        .rs2_i        (rs2_i),
        .imm_i        (imm_i),
        .imem_we_o    (imem_we_o),
        .imem_addr_o  (imem_addr_o),
        .imem_wdata_o (imem_wdata_o),
        .count_o      (count_o),
        .err_o        (err_o),
        .err_code_o   (err_code_o),
        .full_o       (full_o)
`ifdef INSTR_ENCODER_CHECKSUM_EN
       ,.checksum_o   (checksum_o)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: armed = a start has been seen since reset.
    bit m_armed, m_full, m_we, m_err;
    int m_cnt, m_addr, m_wd, m_code, m_cs;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Encoding straight from the format table with integer arithmetic.
    function automatic void ref_enc(input int op, input int rd, input int rs1,
                                    input int rs2, input int imm,
                                    output int word, output int code);
        word = op * 4096 + rd * 512;
        code = 0;
        if (op > 11) code = 1;
        else if (op == 2 || op == 4 || op == 6 || op == 7)
            word += rs1 * 64 + rs2 * 8;
        else if (op == 3 || op == 8 || op == 9) begin
            if (imm < -32 || imm > 31 || imm == 0) code = 2;
            else word += rs1 * 64 + (imm & 63);
        end else if (op == 10 || op == 11)
            word += imm & 511;
        else begin
            if (imm < -64 || imm > 63) code = 2;
            else if (rs1 >= 4)         code = 3;
            else word += (imm & 127) * 4 + (rs1 & 3);
        end
    endfunction

    task automatic drive(input bit v, input int op, input int rd, input int rs1,
                         input int rs2, input int imm);
        in_valid_i = v;
        opcode_i   = 4'(op);
        rd_i       = 3'(rd);
        rs1_i      = 3'(rs1);
        rs2_i      = 3'(rs2);
        imm_i      = 9'(imm);
    endtask

    task automatic cyc();
        int w, c, im;
        @(posedge clk);
        if (!rst_n) begin
            m_armed = 0; m_full = 0; m_we = 0; m_err = 0;
            m_cnt = 0; m_addr = 0; m_wd = 0; m_code = 0; m_cs = 0;
        end else begin
            m_we = 0;
            m_err = 0;
            if (start_i) begin
                m_armed = 1; m_full = 0; m_cnt = 0; m_cs = 0;
            end else if (in_valid_i && m_armed && !m_full) begin
                im = $signed(imm_i);
                ref_enc(opcode_i, rd_i, rs1_i, rs2_i, im, w, c);
                if (c == 0) begin
                    m_we = 1; m_addr = BASE + m_cnt; m_wd = w;
                    m_cnt++; m_cs ^= w;
                    if (m_cnt == DEPTH) m_full = 1;
                end else begin
                    m_err = 1; m_code = c;
                end
            end
        end
        #1;
        chk("we",    imem_we_o,    m_we);
        chk("addr",  imem_addr_o,  m_addr);
        chk("wdata", imem_wdata_o, m_wd);
        chk("count", count_o,      m_cnt);
        chk("err",   err_o,        m_err);
        chk("code",  err_code_o,   m_code);
        chk("full",  full_o,       m_full);
        chk("ready", in_ready_o,   m_armed && !m_full);
`ifdef INSTR_ENCODER_CHECKSUM_EN
        chk("csum",  checksum_o,   m_cs);
`endif
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // Basic R-format write, then N-format zero/nonzero immediates.
        pulse_start();
        drive(1, 4, 1, 2, 3, 0);   cyc();
        chk("wdata_r", imem_wdata_o, 16'h4298);
        drive(0, 0, 0, 0, 0, 0);   cyc();
        pulse_start();
        drive(1, 3, 2, 2, 0, 0);   cyc();
        drive(1, 3, 2, 2, 0, -1);  cyc();
        chk("wdata_n", imem_wdata_o, 16'h34BF);
`ifdef INSTR_ENCODER_CHECKSUM_EN
        pulse_start();
        drive(1, 4, 1, 2, 3, 0);   cyc();
        drive(1, 3, 2, 2, 0, -1);  cyc();
        chk("csum_dir", checksum_o, 16'h7627);
`endif

        // Branch offset extreme, M/K out of range, illegal opcode, rs1[2].
        pulse_start();
        drive(1, 10, 5, 0, 0, -256); cyc();
        chk("wdata_b", imem_wdata_o, 16'hAB00);
        drive(1, 0, 1, 1, 0, 64);    cyc();
        drive(1, 13, 0, 0, 0, 0);    cyc();
        drive(1, 5, 1, 4, 0, 3);     cyc();
        drive(1, 1, 7, 3, 0, -64);   cyc();

        // Fill to DEPTH, hold the extra bundle, then restart with it pending.
        pulse_start();
        for (int i = 0; i < DEPTH + 3; i++) begin
            drive(1, 2, i % 8, 1, 2, 0);
            cyc();
        end
        start_i = 1'b1; cyc(); start_i = 1'b0;
        cyc();

        // Start collides with an acceptance in RUN.
        drive(1, 6, 3, 3, 3, 0);
        start_i = 1'b1; cyc(); start_i = 1'b0;
        cyc(); cyc();

        // Reset mid-stream.
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        cyc();

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            int im;
            if ($urandom_range(0, 1) == 0) im = int'($urandom_range(0, 160)) - 80;
            else                           im = int'($urandom_range(0, 511)) - 256;
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 13),
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), im);
            start_i = ($urandom_range(0, 11) == 0);
            rst_n   = ($urandom_range(0, 63) != 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
